// File: rtl/struct_field_serializer_pkg.sv
// Shared types and defaults for the packed-field serializer and its packer counterpart.
package struct_ser_pkg;

  localparam int unsigned DEFAULT_FIELD_W    = 2;
  localparam int unsigned DEFAULT_NUM_FIELDS = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  // Width of a field index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned num_fields);
    return (num_fields <= 1) ? 1 : $clog2(num_fields);
  endfunction

endpackage

// File: rtl/struct_field_serializer_select.sv
// Combinational field picker: returns field[idx] of a packed word (field 0 in the LSBs).
module struct_field_select
  import struct_ser_pkg::*;
#(
  parameter int unsigned FIELD_W    = DEFAULT_FIELD_W,
  parameter int unsigned NUM_FIELDS = DEFAULT_NUM_FIELDS,
  parameter int unsigned IDX_W      = idx_width(NUM_FIELDS)
) (
  input  logic [FIELD_W*NUM_FIELDS-1:0] word,
  input  logic [IDX_W-1:0]              idx,
  output logic [FIELD_W-1:0]            field
);

  // Compare-and-select keeps out-of-range indices (non power-of-2 counts) at zero.
  always_comb begin
    field = '0;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      if (idx == IDX_W'(k)) begin
        field = word[k*FIELD_W +: FIELD_W];
      end
    end
  end

endmodule

// File: rtl/struct_field_serializer.sv
// Emits the fields of one packed word per handshake, MSB field first, on a valid/ready stream.
// Optional STRUCT_SER_PARITY_EN adds out_parity (XOR reduction of out_field).
module struct_field_serializer
  import struct_ser_pkg::*;
#(
  parameter int unsigned FIELD_W    = DEFAULT_FIELD_W,
  parameter int unsigned NUM_FIELDS = DEFAULT_NUM_FIELDS,
  parameter int unsigned WORD_W     = FIELD_W * NUM_FIELDS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WORD_W-1:0]                  in_word,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [FIELD_W-1:0]                 out_field,
  output logic                               out_last,
  output logic [idx_width(NUM_FIELDS)-1:0]   out_idx
`ifdef STRUCT_SER_PARITY_EN
  ,
  output logic                               out_parity
`endif
);

  localparam int unsigned IDX_W = idx_width(NUM_FIELDS);

  ser_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              idx_zero;
  logic              accept;
  logic [FIELD_W-1:0] sel_field;

  assign idx_zero = (idx_q == '0);
  assign accept   = in_valid && in_ready;

  // Ready in SEND only as the last field leaves, so consecutive words stream without bubbles.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      SEND: in_ready = out_ready && idx_zero;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          idx_d   = IDX_W'(NUM_FIELDS - 1);
          hold_d  = in_word;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (!idx_zero) begin
            idx_d = idx_q - IDX_W'(1);
          end else if (accept) begin
            idx_d  = IDX_W'(NUM_FIELDS - 1);
            hold_d = in_word;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  struct_field_select #(
    .FIELD_W    (FIELD_W),
    .NUM_FIELDS (NUM_FIELDS),
    .IDX_W      (IDX_W)
  ) u_select (
    .word  (hold_q),
    .idx   (idx_q),
    .field (sel_field)
  );

  // Outputs derive only from registered state, so they hold under backpressure.
  assign out_valid = (state_q == SEND);
  assign out_field = out_valid ? sel_field : '0;
  assign out_last  = out_valid && idx_zero;
  assign out_idx   = idx_q;

`ifdef STRUCT_SER_PARITY_EN
  assign out_parity = out_valid && (^sel_field);
`endif

endmodule

// File: tb/tb_struct_field_serializer.sv
// Self-checking bench for struct_field_serializer: directed vector table plus randomized sweep.
module tb_struct_field_serializer;

  localparam int unsigned FW = 2;
  localparam int unsigned NF = 2;
  localparam int unsigned WW = FW * NF;
  localparam int unsigned IW = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] in_word;
  logic          out_valid;
  logic          out_ready;
  logic [FW-1:0] out_field;
  logic          out_last;
  logic [IW-1:0] out_idx;
`ifdef STRUCT_SER_PARITY_EN
  logic          out_parity;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  struct_field_serializer #(
    .FIELD_W    (FW),
    .NUM_FIELDS (NF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_field (out_field),
    .out_last  (out_last),
    .out_idx   (out_idx)
`ifdef STRUCT_SER_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          iv;
    logic [WW-1:0] w;
    logic          ordy;
    logic          ev;
    logic [FW-1:0] ef;
    logic [IW-1:0] ei;
    logic          el;
    logic          erdy;
  } vec_t;

  typedef struct {
    logic [FW-1:0] f;
    logic [IW-1:0] i;
    logic          l;
  } beat_t;

  vec_t  vecs[$];
  beat_t got_q[$];
  beat_t exp_q[$];

  task automatic add(input logic iv, input logic [WW-1:0] w, input logic ordy, input logic ev,
                     input logic [FW-1:0] ef, input logic [IW-1:0] ei, input logic el,
                     input logic erdy);
    vec_t v;
    v = '{iv: iv, w: w, ordy: ordy, ev: ev, ef: ef, ei: ei, el: el, erdy: erdy};
    vecs.push_back(v);
  endtask

  // Transfer monitor and backpressure stability checker, sampled mid-cycle.
  logic          mon_en = 1'b0;
  logic          prev_stall = 1'b0;
  logic [FW-1:0] prev_f;
  logic [IW-1:0] prev_i;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_field", 32'(out_field), 32'(prev_f));
        check("stall_idx", 32'(out_idx), 32'(prev_i));
      end
`ifdef STRUCT_SER_PARITY_EN
      check("parity", 32'(out_parity), out_valid ? 32'(^out_field) : 32'd0);
`endif
      if (mon_en && out_valid && out_ready) begin
        got_q.push_back('{f: out_field, i: out_idx, l: out_last});
      end
      prev_stall = out_valid && !out_ready;
      prev_f     = out_field;
      prev_i     = out_idx;
    end
  end

  function automatic void model_push(input logic [WW-1:0] w);
    for (int k = NF - 1; k >= 0; k--) begin
      exp_q.push_back('{f: w[k*FW +: FW], i: IW'(k), l: (k == 0)});
    end
  endfunction

  initial begin
    int w;
    int gap;
    int cyc;
    logic [WW-1:0] wv;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_field", 32'(out_field), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("rst_release_in_ready", 32'(in_ready), 32'd1);

    // Single word 1101
    add(1, 4'b1101, 1, 0, 2'b00, 0, 0, 1);
    add(0, 4'b0000, 1, 1, 2'b11, 1, 0, 0);
    add(0, 4'b0000, 1, 1, 2'b01, 0, 1, 1);
    add(0, 4'b0000, 1, 0, 2'b00, 0, 0, 1);
    // Backpressure on word 1001
    add(1, 4'b1001, 0, 0, 2'b00, 0, 0, 1);
    add(0, 4'b0000, 0, 1, 2'b10, 1, 0, 0);
    add(0, 4'b0000, 0, 1, 2'b10, 1, 0, 0);
    add(0, 4'b0000, 0, 1, 2'b10, 1, 0, 0);
    add(0, 4'b0000, 1, 1, 2'b10, 1, 0, 0);
    add(0, 4'b0000, 0, 1, 2'b01, 0, 1, 0);
    add(0, 4'b0000, 1, 1, 2'b01, 0, 1, 1);
    add(0, 4'b0000, 1, 0, 2'b00, 0, 0, 1);
    // Back-to-back 0110 then 1011
    add(1, 4'b0110, 1, 0, 2'b00, 0, 0, 1);
    add(1, 4'b1011, 1, 1, 2'b01, 1, 0, 0);
    add(1, 4'b1011, 1, 1, 2'b10, 0, 1, 1);
    add(0, 4'b0000, 1, 1, 2'b10, 1, 0, 0);
    add(0, 4'b0000, 1, 1, 2'b11, 0, 1, 1);
    add(0, 4'b0000, 1, 0, 2'b00, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(posedge clk);
      #1;
      in_valid  = v.iv;
      in_word   = v.w;
      out_ready = v.ordy;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(v.ev));
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(v.erdy));
      if (v.ev) begin
        check($sformatf("vec%0d_field", i), 32'(out_field), 32'(v.ef));
        check($sformatf("vec%0d_idx", i), 32'(out_idx), 32'(v.ei));
        check($sformatf("vec%0d_last", i), 32'(out_last), 32'(v.el));
      end
    end

    // Reset while field 1 of word 1110 is pending
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_word   = 4'b1110;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("midrst_pre_valid", 32'(out_valid), 32'd1);
    check("midrst_pre_idx", 32'(out_idx), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_idx", 32'(out_idx), 32'd0);
    check("midrst_last", 32'(out_last), 32'd0);
    check("midrst_field", 32'(out_field), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    mon_en    = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_word   = 4'b0100;
    model_push(4'b0100);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("midrst_beat%0d_field", i), 32'(got_q[i].f), 32'(exp_q[i].f));
      check($sformatf("midrst_beat%0d_idx", i), 32'(got_q[i].i), 32'(exp_q[i].i));
    end

    // Randomized sweep of every word value with random gaps and backpressure
    got_q.delete();
    exp_q.delete();
    w   = 0;
    gap = 0;
    cyc = 0;
    while (w < (1 << WW) && cyc < 2000) begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (gap == 0) begin
        in_valid = 1'b1;
        in_word  = WW'(w);
      end else begin
        in_valid = 1'b0;
        gap--;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        wv = WW'(w);
        model_push(wv);
        w++;
        gap = $urandom_range(0, 2);
      end
      cyc++;
    end
    check("sweep_all_accepted", 32'(w), 32'(1 << WW));
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (got_q.size() < exp_q.size() && cyc < 50) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check("sweep_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("sweep_beat%0d_field", i), 32'(got_q[i].f), 32'(exp_q[i].f));
      check($sformatf("sweep_beat%0d_idx", i), 32'(got_q[i].i), 32'(exp_q[i].i));
      check($sformatf("sweep_beat%0d_last", i), 32'(got_q[i].l), 32'(exp_q[i].l));
    end
    check("idle_after_sweep", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
